// File: rtl/bcd_stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the two-digit BCD stopwatch:
//                FSM state encoding, BCD limit, blank code and digit-select
//                encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic       SEL_ONES    = 1'b0;
    localparam logic       SEL_TENS    = 1'b1;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/bcd_stopwatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_if
//  Description : Control/display bundle of the stopwatch.
//                ena, btn_start, btn_clear : toward the stopwatch
//                digit_out[3:0], digit_sel, running, wrap : from the stopwatch
//                slave modport = stopwatch side, master modport = driver side.
//  Revision    : 1.0  initial release
// ============================================================================
interface bcd_stopwatch_if;
    logic       ena;
    logic       btn_start;
    logic       btn_clear;
    logic [3:0] digit_out;
    logic       digit_sel;
    logic       running;
    logic       wrap;

    modport slave (
        input  ena,
        input  btn_start,
        input  btn_clear,
        output digit_out,
        output digit_sel,
        output running,
        output wrap
    );

    modport master (
        output ena,
        output btn_start,
        output btn_clear,
        input  digit_out,
        input  digit_sel,
        input  running,
        input  wrap
    );
endinterface : bcd_stopwatch_if
`default_nettype wire

// File: rtl/bcd_stopwatch_btn_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : btn_sync_edge
//  Description : Two-flop synchronizer followed by a rising-edge detector.
//                Produces a single-cycle pulse per button press.
//                clk, rst_n : clock, asynchronous active-low reset
//                ena        : pulse qualifier (synchronizer keeps running)
//                async_in   : raw button input
//                pulse      : one-cycle pulse on a synchronized rising edge
//  Revision    : 1.0  initial release
// ============================================================================
module btn_sync_edge (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  ena,
    input  wire  async_in,
    output logic pulse
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // The flops always advance, even with ena low, so a press that lands
    // while disabled is consumed and not replayed once ena returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Combinational pulse so the consumer acts on the third edge after the
    // input is first sampled high.
    assign pulse = ena & sync2_q & ~prev_q;

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch
//  Description : Two-digit BCD stopwatch (00-99) with start/stop and clear
//                buttons, tick prescaler and time-multiplexed digit output
//                with optional leading-zero blanking.
//                clk   : system clock
//                rst_n : asynchronous active-low reset
//                sw    : control/display bundle (slave side)
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1000000,
    parameter int MUX_DIV  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  wire             clk,
    input  wire             rst_n,
    bcd_stopwatch_if.slave  sw
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (MUX_DIV  > 1) ? $clog2(MUX_DIV)  : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] MUX_LAST   = MW'(MUX_DIV - 1);

    logic          start_pulse;
    logic          clear_pulse;

    state_e        state_q, state_d;
    logic [3:0]    ones_q,  ones_d;
    logic [3:0]    tens_q,  tens_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [MW-1:0] mux_q,   mux_d;
    logic          sel_q,   sel_d;
    logic          wrap_q,  wrap_d;

    btn_sync_edge u_start (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (sw.ena),
        .async_in (sw.btn_start),
        .pulse    (start_pulse)
    );

    btn_sync_edge u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (sw.ena),
        .async_in (sw.btn_clear),
        .pulse    (clear_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            presc_q <= '0;
            mux_q   <= '0;
            sel_q   <= SEL_ONES;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            presc_q <= presc_d;
            mux_q   <= mux_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        presc_d = presc_q;
        mux_d   = mux_q;
        sel_d   = sel_q;
        wrap_d  = 1'b0;

        if (sw.ena) begin
            // Display slot timer runs in every state.
            if (mux_q == MUX_LAST) begin
                mux_d = '0;
                sel_d = ~sel_q;
            end else begin
                mux_d = mux_q + 1'b1;
            end

            if (clear_pulse) begin
                // Clear overrides any tick or start in the same cycle.
                state_d = IDLE;
                ones_d  = 4'd0;
                tens_d  = 4'd0;
                presc_d = '0;
            end else begin
                // Prescaler only advances in RUN; PAUSE keeps the partial
                // interval so a resume completes it.
                if (state_q == RUN) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (ones_q == BCD_MAX) begin
                            ones_d = 4'd0;
                            if (tens_q == BCD_MAX) begin
                                tens_d = 4'd0;
                                wrap_d = 1'b1;
                            end else begin
                                tens_d = tens_q + 4'd1;
                            end
                        end else begin
                            ones_d = ones_q + 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end

                if (start_pulse) begin
                    case (state_q)
                        IDLE:    state_d = RUN;
                        RUN:     state_d = PAUSE;
                        PAUSE:   state_d = RUN;
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        sw.digit_out = ones_q;
        if (sel_q == SEL_TENS) begin
            if ((BLANK_LZ != 0) && (tens_q == 4'd0)) begin
                sw.digit_out = DIGIT_BLANK;
            end else begin
                sw.digit_out = tens_q;
            end
        end
    end

    assign sw.digit_sel = sel_q;
    assign sw.running   = (state_q == RUN);
    assign sw.wrap      = wrap_q;

endmodule : bcd_stopwatch
`default_nettype wire

// File: tb/tb_bcd_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_stopwatch
//  Description : Self-checking bench for bcd_stopwatch (TICK_DIV=4,
//                MUX_DIV=3). Two instances run in lockstep, one with leading
//                zero blanking and one without. A table of button/wait steps
//                with hand-computed results drives the main sequence; the
//                held-button, pause/resume, mux, enable and async reset
//                corners are written out by hand.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_stopwatch;

    logic clk;
    logic rst_n;
    logic ena;
    logic btn_start;
    logic btn_clear;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_stopwatch_if sw1 ();
    bcd_stopwatch_if sw2 ();

    assign sw1.ena       = ena;
    assign sw1.btn_start = btn_start;
    assign sw1.btn_clear = btn_clear;
    assign sw2.ena       = ena;
    assign sw2.btn_start = btn_start;
    assign sw2.btn_clear = btn_clear;

    bcd_stopwatch #(.TICK_DIV(4), .MUX_DIV(3), .BLANK_LZ(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw1)
    );

    bcd_stopwatch #(.TICK_DIV(4), .MUX_DIV(3), .BLANK_LZ(0)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic start;
        logic clear;
        int   wait_cyc;
        logic exp_run;
        int   exp_tens;
        int   exp_ones;
        logic exp_wrap;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge at which the FSM acts on the press.
    task automatic press(input logic s, input logic c);
        @(negedge clk);
        btn_start = s;
        btn_clear = c;
        @(negedge clk);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag, input int t, input int o);
        check({tag, " tens"}, 32'(u_dut1.tens_q), 32'(t));
        check({tag, " ones"}, 32'(u_dut1.ones_q), 32'(o));
    endtask

    // Count must be frozen (paused) while this runs.
    task automatic check_mux(input string tag, input logic [3:0] e_ones,
                             input logic [3:0] e_t1, input logic [3:0] e_t2);
        logic prev;
        logic esel;
        int   k;
        prev = sw1.digit_sel;
        k    = 0;
        while (sw1.digit_sel == prev && k < 6) begin
            step(1);
            k++;
        end
        check({tag, " first toggle within 3"}, 32'(k <= 3), 32'd1);
        for (int i = 0; i < 12; i++) begin
            esel = (~prev) ^ logic'((i / 3) % 2);
            check($sformatf("%s sel[%0d]", tag, i), 32'(sw1.digit_sel), 32'(esel));
            check($sformatf("%s sel2[%0d]", tag, i), 32'(sw2.digit_sel), 32'(esel));
            check($sformatf("%s out1[%0d]", tag, i), 32'(sw1.digit_out), 32'(esel ? e_t1 : e_ones));
            check($sformatf("%s out2[%0d]", tag, i), 32'(sw2.digit_out), 32'(esel ? e_t2 : e_ones));
            step(1);
        end
    endtask

    logic sel_before;

    initial begin
        //          start clear wait run tens ones wrap
        vecs[0]  = '{1'b1, 1'b0,   0, 1'b1, 0, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0,   4, 1'b1, 0, 1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0,   8, 1'b1, 0, 3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0,   0, 1'b0, 0, 3, 1'b0};
        vecs[4]  = '{1'b0, 1'b0,  50, 1'b0, 0, 3, 1'b0};
        vecs[5]  = '{1'b1, 1'b0,   0, 1'b1, 0, 3, 1'b0};
        vecs[6]  = '{1'b0, 1'b0,   1, 1'b1, 0, 4, 1'b0};
        vecs[7]  = '{1'b0, 1'b0,  24, 1'b1, 1, 0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 356, 1'b1, 9, 9, 1'b0};
        vecs[9]  = '{1'b0, 1'b0,   4, 1'b1, 0, 0, 1'b1};
        vecs[10] = '{1'b0, 1'b0,   1, 1'b1, 0, 0, 1'b0};
        vecs[11] = '{1'b0, 1'b1,   0, 1'b0, 0, 0, 1'b0};
        vecs[12] = '{1'b0, 1'b0,  10, 1'b0, 0, 0, 1'b0};
        vecs[13] = '{1'b1, 1'b0,   0, 1'b1, 0, 0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 148, 1'b1, 3, 7, 1'b0};
        vecs[15] = '{1'b1, 1'b1,   0, 1'b0, 0, 0, 1'b0};

        rst_n     = 1'b0;
        ena       = 1'b1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        #2;
        check("reset digit_out", 32'(sw1.digit_out), 32'd0);
        check("reset digit_sel", 32'(sw1.digit_sel), 32'd0);
        check("reset running",   32'(sw1.running),   32'd0);
        check("reset wrap",      32'(sw1.wrap),      32'd0);
        check_count("reset", 0, 0);
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // Main table-driven sequence.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].start || vecs[i].clear)
                press(vecs[i].start, vecs[i].clear);
            if (vecs[i].wait_cyc > 0)
                step(vecs[i].wait_cyc);
            check($sformatf("vec%0d running", i), 32'(sw1.running), 32'(vecs[i].exp_run));
            check($sformatf("vec%0d wrap", i), 32'(sw1.wrap), 32'(vecs[i].exp_wrap));
            check_count($sformatf("vec%0d", i), vecs[i].exp_tens, vecs[i].exp_ones);
            check($sformatf("vec%0d out2", i), 32'(sw2.digit_out),
                  32'(sw2.digit_sel ? vecs[i].exp_tens : vecs[i].exp_ones));
        end

        // Held start: one pulse only, then a fresh press pauses.
        @(negedge clk);
        btn_start = 1'b1;
        step(20);
        check("held running", 32'(sw1.running), 32'd1);
        check_count("held", 0, 4);
        @(negedge clk);
        btn_start = 1'b0;
        press(1'b1, 1'b0);
        check("repress running", 32'(sw1.running), 32'd0);
        check_count("repress", 0, 5);
        step(20);
        check("frozen running", 32'(sw1.running), 32'd0);
        check_count("frozen", 0, 5);

        // Pause at 05 with prescaler 2, resume completes partial interval.
        press(1'b0, 1'b1);
        check("clr running", 32'(sw1.running), 32'd0);
        check_count("clr", 0, 0);
        press(1'b1, 1'b0);
        step(19);
        press(1'b1, 1'b0);
        check("p05 running", 32'(sw1.running), 32'd0);
        check_count("p05", 0, 5);
        step(50);
        check_count("p05 hold", 0, 5);
        press(1'b1, 1'b0);
        check("resume running", 32'(sw1.running), 32'd1);
        check_count("resume+0", 0, 5);
        step(1);
        check_count("resume+1", 0, 5);
        step(1);
        check_count("resume+2", 0, 6);

        // Display mux at 07 and at 42.
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        step(25);
        press(1'b1, 1'b0);
        check_count("c07", 0, 7);
        check_mux("c07", 4'd7, 4'hF, 4'd0);
        press(1'b1, 1'b0);
        step(137);
        press(1'b1, 1'b0);
        check_count("c42", 4, 2);
        check_mux("c42", 4'd2, 4'd4, 4'd4);

        // ena low freezes everything and swallows a press.
        press(1'b1, 1'b0);
        check("ena resume running", 32'(sw1.running), 32'd1);
        sel_before = sw1.digit_sel;
        @(negedge clk);
        ena = 1'b0;
        step(10);
        check_count("ena0", 4, 2);
        check("ena0 sel", 32'(sw1.digit_sel), 32'(sel_before));
        press(1'b1, 1'b0);
        step(5);
        check("ena0 running", 32'(sw1.running), 32'd1);
        check("ena0 sel late", 32'(sw1.digit_sel), 32'(sel_before));
        check("ena0 wrap", 32'(sw1.wrap), 32'd0);
        check_count("ena0 late", 4, 2);
        @(negedge clk);
        ena = 1'b1;
        step(6);
        check("ena1 running", 32'(sw1.running), 32'd1);
        check_count("ena1", 4, 3);

        // Asynchronous reset mid-RUN, observed before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst digit_out1", 32'(sw1.digit_out), 32'd0);
        check("arst digit_out2", 32'(sw2.digit_out), 32'd0);
        check("arst digit_sel",  32'(sw1.digit_sel), 32'd0);
        check("arst running",    32'(sw1.running),   32'd0);
        check("arst wrap",       32'(sw1.wrap),      32'd0);
        check_count("arst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(10);
        check("post arst running", 32'(sw1.running), 32'd0);
        check_count("post arst", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd_stopwatch
`default_nettype wire
